round_scheduler: RTL and testbench
==================================

// Module: round_scheduler
// PURPOSE
//  Top-level sequencer for the encoder permutation. Runs NUM_ROUNDS rounds of NUM_STEPS step
//  controllers in fixed order: theta, rho, pi, chi, addRC (step_idx 0..4).
//  Each step controller is launched with a one-cycle enable and answers with a one-cycle done.
//  Publishes round_idx so the addRC step can select its round constant. A watchdog flags any step that hangs.
// PARAMETERS
//  NUM_ROUNDS  24   rounds per permutation
//  NUM_STEPS   5    step controllers per round (one-hot enable/done width)
//  RIDX_W      5    width of round_idx, must satisfy 2**RIDX_W >= NUM_ROUNDS
//  TIMEOUT     512  max cycles in WAIT for a single step before ERR
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  start      in   1          begin a permutation; sampled only in IDLE
//  abort      in   1          return to IDLE next cycle from any state
//  step_done  in   NUM_STEPS  one-cycle done pulse per step controller
//  step_en    out  NUM_STEPS  one-hot, one-cycle launch pulse to step controller step_idx
//  round_idx  out  RIDX_W     current round, 0..NUM_ROUNDS-1, stable for the whole round
//  busy       out  1          high in LAUNCH, WAIT and NEXT
//  done       out  1          one-cycle pulse when the permutation is complete
//  error      out  1          high in ERR, held until rst or abort
// BEHAVIOUR
//  Reset values: state=IDLE, step_idx=0, round_idx=0, wdog=0; all outputs 0.
//  Outputs are Moore-decoded from the state register only. There is no combinational input-to-output path.
//  States and transitions:
//   IDLE:   start -> LAUNCH. step_idx and round_idx are cleared to 0.
//   LAUNCH: step_en[step_idx]=1 for exactly 1 cycle; wdog cleared; -> WAIT.
//   WAIT:   step_done[step_idx] -> NEXT.
//           Any other step_done bit set -> ERR. This check takes priority over a matching done in the same cycle.
//           wdog == TIMEOUT-1 with no done -> ERR. Otherwise wdog++.
//   NEXT:   step_idx < NUM_STEPS-1 -> step_idx++, go to LAUNCH.
//           Else step_idx=0; if round_idx==NUM_ROUNDS-1 -> FINISH, otherwise round_idx++ and go to LAUNCH.
//   FINISH: done=1 for 1 cycle -> IDLE. round_idx holds NUM_ROUNDS-1 until the next start.
//   ERR:    error=1. Stays here until abort or rst.
//  Priority in every state: rst > abort > normal transitions. Abort and start together in IDLE -> stay IDLE.
//  step_done pulses seen outside WAIT are ignored, including a late pulse after abort.
//  Start pulses seen while not in IDLE are ignored; there is no queuing.
//  Abort or reset mid-operation: step_en deasserts on the next cycle and counters clear.
//   Step controllers are not reset by this block.
//  Timing: start sampled at edge 0 -> LAUNCH at cycle 1.
//   With zero-wait steps (done returned the cycle after step_en), each step takes 3 cycles (LAUNCH, WAIT, NEXT).
//   Step k (0..NUM_ROUNDS*NUM_STEPS-1) has LAUNCH at cycle 1+3k.
//   Defaults give FINISH (done high) at cycle 361.
//  round_idx changes only in the NEXT state that ends a round, i.e. never while a step is active.
//  Counter widths: step_idx uses $clog2(NUM_STEPS) bits, wdog uses $clog2(TIMEOUT) bits; both wrap-free by construction.
// STRUCTURE
//  Shared package enc_pkg: state encoding (IDLE..ERR, 3 bits);
//   step index constants STEP_THETA=0, STEP_RHO=1, STEP_PI=2, STEP_CHI=3, STEP_ADDRC=4;
//   NUM_ROUNDS and RIDX_W defaults.
//  Sub-module step_watchdog: clear/enable/timeout counter holding the wdog logic, reusable by the other step controllers.
//  Everything else stays in this module: state register, next-state logic, output decode, round and step counters.
// TESTING
//  1 Reset, then start with every step controller answering done 1 cycle after its step_en
//    -> 120 step_en pulses in order 0,1,2,3,4 repeating; round_idx steps 0..23; done at cycle 361; busy low after.
//  2 Step 2 of round 7 answers after 40 cycles, all others immediate
//    -> total latency grows by exactly 39 cycles; round_idx stays 7 throughout the wait; no error.
//  3 Step 3 of round 0 never answers -> error rises 512 cycles after WAIT entry;
//    no further step_en; abort -> IDLE with error=0 the next cycle.
//  4 While waiting on step 1, inject step_done=5'b01000 -> ERR on the next cycle; done never asserts.
//  5 Abort during round 12 WAIT, then a late step_done, then start
//    -> the late done is ignored; the new run begins at round_idx=0, step_idx=0 and completes normally.
//  6 Start held high through a full run, plus start and abort together in IDLE
//    -> no re-launch while busy; stays IDLE when start and abort coincide; rst mid-run clears all outputs on the next edge.

Source files
------------

// File: rtl/enc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// enc_pkg : shared state encoding and step constants for the permutation
// Rev 1.0
// ---------------------------------------------------------------------------
package enc_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_NEXT   = 3'd3,
      S_FINISH = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   localparam int STEP_THETA = 0;
   localparam int STEP_RHO   = 1;
   localparam int STEP_PI    = 2;
   localparam int STEP_CHI   = 3;
   localparam int STEP_ADDRC = 4;

   localparam int DEF_NUM_ROUNDS = 24;
   localparam int DEF_RIDX_W     = 5;

endpackage
`default_nettype wire

// File: rtl/step_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// step_watchdog : clear/enable cycle counter flagging a step that never ends
// Rev 1.0
// ---------------------------------------------------------------------------
module step_watchdog #(
   parameter int TIMEOUT = 512
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int               CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] wdog;

   // Saturates at LAST so the counter can never wrap back to zero.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wdog <= '0;
      end else if (enable && !expired) begin
         wdog <= wdog + 1'b1;
      end
   end

   assign expired = (wdog == LAST);

endmodule
`default_nettype wire

// File: rtl/round_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// round_scheduler : sequences NUM_ROUNDS x NUM_STEPS step controllers
// Rev 1.0
// ---------------------------------------------------------------------------
module round_scheduler
   import enc_pkg::*;
#(
   parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
   parameter int NUM_STEPS  = 5,
   parameter int RIDX_W     = DEF_RIDX_W,
   parameter int TIMEOUT    = 512
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NUM_STEPS-1:0] step_done,
   output logic [NUM_STEPS-1:0] step_en,
   output logic [RIDX_W-1:0]    round_idx,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);

   localparam int                    SIDX_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam logic [SIDX_W-1:0]     LAST_STEP  = SIDX_W'(NUM_STEPS - 1);
   localparam logic [RIDX_W-1:0]     LAST_ROUND = RIDX_W'(NUM_ROUNDS - 1);
   localparam logic [NUM_STEPS-1:0]  ONE        = {{(NUM_STEPS-1){1'b0}}, 1'b1};

   state_t                 state;
   logic [SIDX_W-1:0]      step_idx;
   logic [NUM_STEPS-1:0]   cur_mask;
   logic                   hit;
   logic                   stray;
   logic                   wd_expired;

   assign cur_mask = ONE << step_idx;
   assign hit      = |(step_done & cur_mask);
   assign stray    = |(step_done & ~cur_mask);

   step_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clear   ((state == S_LAUNCH) || abort),
      .enable  (state == S_WAIT),
      .expired (wd_expired)
   );

   // Outputs are registered alongside the state so they depend on no input combinationally.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         state     <= S_IDLE;
         step_idx  <= '0;
         round_idx <= '0;
         step_en   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         step_en <= '0;
         done    <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_LAUNCH;
                  step_idx  <= '0;
                  round_idx <= '0;
                  step_en   <= ONE;
                  busy      <= 1'b1;
               end
            end
            S_LAUNCH: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               // A done from the wrong controller outranks the expected one.
               if (stray || (!hit && wd_expired)) begin
                  state <= S_ERR;
                  busy  <= 1'b0;
                  error <= 1'b1;
               end else if (hit) begin
                  state <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (step_idx < LAST_STEP) begin
                  step_idx <= step_idx + 1'b1;
                  step_en  <= ONE << (step_idx + 1'b1);
                  state    <= S_LAUNCH;
               end else begin
                  step_idx <= '0;
                  if (round_idx == LAST_ROUND) begin
                     state <= S_FINISH;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     round_idx <= round_idx + 1'b1;
                     step_en   <= ONE;
                     state     <= S_LAUNCH;
                  end
               end
            end
            S_FINISH: begin
               state <= S_IDLE;
            end
            S_ERR: begin
               state <= S_ERR;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               error <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_round_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_round_scheduler : self-checking bench for round_scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_round_scheduler;

   localparam int NR    = 24;
   localparam int NS    = 5;
   localparam int NSTEP = NR * NS;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [4:0] step_done;
   logic [4:0] step_en;
   logic [4:0] round_idx;
   logic       busy;
   logic       done;
   logic       error;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int base  = 0;
   int extra = 0;
   int lat [NSTEP];

   round_scheduler #(
      .NUM_ROUNDS (NR),
      .NUM_STEPS  (NS),
      .RIDX_W     (5),
      .TIMEOUT    (512)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .step_done (step_done),
      .step_en   (step_en),
      .round_idx (round_idx),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Serves steps first..first+n-1; latency 0 means the step is launched but never answered.
   task automatic serve_steps(input int first, input int n);
      for (int k = first; k < first + n; k++) begin
         int         guard;
         logic [4:0] exp_en;
         guard  = 0;
         exp_en = 5'b00001;
         exp_en = exp_en << (k % NS);
         while (step_en == 5'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         total++;
         if (guard >= 200) begin
            bad++;
            $display("FAIL launch_wait step=%0d: no step_en within 200 cycles", k);
            return;
         end
         total++;
         if ((cyc - base) !== (1 + 3 * k + extra)) begin
            bad++;
            $display("FAIL launch_cycle step=%0d: got %0d want %0d", k, cyc - base, 1 + 3 * k + extra);
         end
         total++;
         if (step_en !== exp_en) begin
            bad++;
            $display("FAIL step_en step=%0d: got %b want %b", k, step_en, exp_en);
         end
         total++;
         if (round_idx !== 5'(k / NS) || busy !== 1'b1) begin
            bad++;
            $display("FAIL launch_state step=%0d: round=%0d busy=%b want round=%0d busy=1", k, round_idx, busy, k / NS);
         end
         if (lat[k] == 0) return;
         for (int j = 0; j < lat[k]; j++) begin
            @(negedge clk);
            total++;
            if (step_en !== 5'b0 || round_idx !== 5'(k / NS) || error !== 1'b0) begin
               bad++;
               $display("FAIL wait_stable step=%0d: en=%b round=%0d err=%b want en=0 round=%0d err=0",
                        k, step_en, round_idx, error, k / NS);
            end
         end
         step_done = exp_en;
         @(negedge clk);
         step_done = 5'b0;
         extra += lat[k] - 1;
      end
   endtask

   task automatic kick_start(input bit hold);
      extra = 0;
      start = 1'b1;
      base  = cyc;
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   task automatic run_full(input bit hold);
      int guard;
      kick_start(hold);
      serve_steps(0, NSTEP);
      guard = 0;
      while (done !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      start = 1'b0;
      total++;
      if (guard >= 50) begin
         bad++;
         $display("FAIL done_wait: done not seen within 50 cycles");
         return;
      end
      total++;
      if ((cyc - base) !== (1 + 3 * NSTEP + extra)) begin
         bad++;
         $display("FAIL done_cycle: got %0d want %0d", cyc - base, 1 + 3 * NSTEP + extra);
      end
      total++;
      if (busy !== 1'b0 || round_idx !== 5'(NR - 1) || error !== 1'b0) begin
         bad++;
         $display("FAIL finish_state: busy=%b round=%0d err=%b want 0/%0d/0", busy, round_idx, error, NR - 1);
      end
      repeat (2) begin
         @(negedge clk);
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || step_en !== 5'b0 || round_idx !== 5'(NR - 1)) begin
            bad++;
            $display("FAIL after_done: done=%b busy=%b en=%b round=%0d want 0/0/0/%0d",
                     done, busy, step_en, round_idx, NR - 1);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; step_done = 5'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({step_en, round_idx, busy, done, error} !== 13'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 0", {step_en, round_idx, busy, done, error});
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({step_en, busy, done, error} !== 8'b0) begin
         bad++;
         $display("FAIL idle_outputs: got %b want 0", {step_en, busy, done, error});
      end
   endtask

   task automatic test_basic();
      for (int k = 0; k < NSTEP; k++) lat[k] = 1;
      run_full(1'b0);
   endtask

   task automatic test_slow_step();
      for (int k = 0; k < NSTEP; k++) lat[k] = 1;
      lat[7 * NS + 2] = 40;
      run_full(1'b0);
   endtask

   task automatic test_random_latency();
      for (int k = 0; k < NSTEP; k++) lat[k] = $urandom_range(1, 4);
      run_full(1'b0);
   endtask

   task automatic test_timeout();
      for (int k = 0; k < NSTEP; k++) lat[k] = 1;
      lat[3] = 0;
      kick_start(1'b0);
      serve_steps(0, 4);
      // WAIT for step 3 begins one cycle after its launch; ERR follows 512 cycles later.
      for (int j = 1; j <= 513; j++) begin
         @(negedge clk);
         total++;
         if (error !== (j == 513) || step_en !== 5'b0) begin
            bad++;
            $display("FAIL timeout_edge j=%0d: err=%b en=%b want err=%0d en=0", j, error, step_en, j == 513);
         end
      end
      repeat (20) begin
         @(negedge clk);
         total++;
         if (error !== 1'b1 || busy !== 1'b0 || step_en !== 5'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL err_hold: err=%b busy=%b en=%b done=%b want 1/0/0/0", error, busy, step_en, done);
         end
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total++;
      if (error !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_clear_err: err=%b busy=%b want 0/0", error, busy);
      end
   endtask

   task automatic test_stray_done();
      logic [4:0] pats [2];
      pats[0] = 5'b01000;
      pats[1] = 5'b01010;
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < NSTEP; k++) lat[k] = 1;
         lat[1] = 0;
         kick_start(1'b0);
         serve_steps(0, 2);
         @(negedge clk);
         step_done = pats[p];
         @(negedge clk);
         step_done = 5'b0;
         total++;
         if (error !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stray_err pat=%b: err=%b busy=%b want 1/0", pats[p], error, busy);
         end
         repeat (30) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || step_en !== 5'b0 || error !== 1'b1) begin
               bad++;
               $display("FAIL stray_hold pat=%b: done=%b en=%b err=%b want 0/0/1", pats[p], done, step_en, error);
            end
         end
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
      end
   endtask

   task automatic test_abort_mid();
      for (int k = 0; k < NSTEP; k++) lat[k] = 1;
      lat[12 * NS] = 0;
      kick_start(1'b0);
      serve_steps(0, 12 * NS + 1);
      @(negedge clk);
      total++;
      if (round_idx !== 5'd12 || busy !== 1'b1) begin
         bad++;
         $display("FAIL pre_abort: round=%0d busy=%b want 12/1", round_idx, busy);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || step_en !== 5'b0 || round_idx !== 5'd0 || error !== 1'b0) begin
         bad++;
         $display("FAIL abort_state: busy=%b en=%b round=%0d err=%b want 0/0/0/0", busy, step_en, round_idx, error);
      end
      step_done = 5'b00001;
      @(negedge clk);
      step_done = 5'b0;
      repeat (5) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || step_en !== 5'b0 || error !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL late_done: busy=%b en=%b err=%b done=%b want all 0", busy, step_en, error, done);
         end
      end
      for (int k = 0; k < NSTEP; k++) lat[k] = 1;
      run_full(1'b0);
   endtask

   task automatic test_start_abort();
      for (int k = 0; k < NSTEP; k++) lat[k] = 1;
      run_full(1'b1);
      start = 1'b1;
      abort = 1'b1;
      repeat (3) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || step_en !== 5'b0) begin
            bad++;
            $display("FAIL start_abort_idle: busy=%b en=%b want 0/0", busy, step_en);
         end
      end
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      kick_start(1'b0);
      serve_steps(0, 7);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({step_en, round_idx, busy, done, error} !== 13'b0) begin
         bad++;
         $display("FAIL rst_mid_run: got %b want 0", {step_en, round_idx, busy, done, error});
      end
      repeat (3) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || step_en !== 5'b0) begin
            bad++;
            $display("FAIL rst_stays_idle: busy=%b en=%b want 0/0", busy, step_en);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_slow_step();
      test_random_latency();
      test_timeout();
      test_stray_done();
      test_abort_mid();
      test_start_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
